imem_boot_loader: RTL and testbench

- Sequences program loading into the writable instruction memory from an 8-bit byte stream (UART/debug bridge), then hands the memory address port to the fetch stage.
- Holds the CPU core in reset for the whole load and releases it only after a complete, valid image has been written.
- Sits between the byte-stream source, the instruction memory write/address port and the core's reset input.

---
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed little-endian image from a byte
// stream into instruction memory while holding the core in reset, then hands
// the memory address port over to the fetch PC.
module imem_boot_loader #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned DEPTH         = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  input  logic [ADDRESS_WIDTH-1:0]   pc,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [INSTR_WIDTH-1:0]     mem_wdata,
  output logic                       mem_we,
  output logic                       cpu_rst,
  output logic                       load_done,
  output logic                       load_error,
  output logic [$clog2(DEPTH):0]     word_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [7:0]           len_lo;
  logic [LEN_W-1:0]     len;
  logic [LEN_W-1:0]     len_in;
  logic [1:0]           byte_idx;
  logic [IDX_W-1:0]     word_idx;
  logic [INSTR_WIDTH-1:0] asm_word;
  logic [CNT_W-1:0]     wcnt;
  logic                 xfer;
  logic                 start_ok;
  logic                 len_bad;
  logic                 last_word;

  // Header and word-completion decodes
  assign len_in    = {rx_data, len_lo};
  assign len_bad   = (len_in == '0) || (len_in > LEN_W'(DEPTH));
  assign last_word = ((LEN_W'(wcnt) + LEN_W'(1)) == len);
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign xfer      = rx_valid && rx_ready;

  assign mem_wdata  = asm_word;
  assign word_count = wcnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; rx_ready/mem_we depend on state only
  always_comb begin
    state_nxt  = state;
    rx_ready   = 1'b0;
    mem_we     = 1'b0;
    cpu_rst    = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    mem_addr   = ADDRESS_WIDTH'({word_idx, 2'b00});
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEN0;
      end
      S_LEN0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (byte_idx == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        state_nxt = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        cpu_rst   = 1'b0;
        load_done = 1'b1;
        mem_addr  = pc;
        if (start) state_nxt = S_LEN0;
      end
      S_ERROR: begin
        load_error = 1'b1;
        if (start) state_nxt = S_LEN0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Header capture, word assembly and address/byte indices
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo   <= '0;
      len      <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      asm_word <= '0;
    end else begin
      if (start_ok) begin
        byte_idx <= '0;
        word_idx <= '0;
      end
      case (state)
        S_LEN0: if (xfer) len_lo <= rx_data;
        S_LEN1: begin
          if (xfer) begin
            len      <= len_in;
            byte_idx <= '0;
            word_idx <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            asm_word <= {rx_data, asm_word[INSTR_WIDTH-1:8]};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          byte_idx <= '0;
          if (!last_word) word_idx <= word_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Words written in the current or last load
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (start_ok) begin
      wcnt <= '0;
    end else if (state == S_WRITE) begin
      wcnt <= wcnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: cycle vector table plus directed sequences.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_rst;
  logic        load_done;
  logic        load_error;
  logic [6:0]  word_count;

  imem_boot_loader #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cpu_rst(cpu_rst), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, vld;
    logic [7:0]  d;
    logic [31:0] pc;
    logic        rdy, we;
    logic [31:0] addr;
    logic        ca;
    logic [31:0] wdata;
    logic        cw;
    logic        cpu, done, err;
    logic [6:0]  wc;
  } vec_t;

  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] wr_addr[0:127];
  logic [31:0] wr_data[0:127];
  int          wr_n = 0;
  logic [31:0] img[0:63];

  function automatic vec_t mk(input logic r, s, v, input logic [7:0] d, input logic [31:0] p,
                              input logic rdy, we, input logic [31:0] addr, input logic ca,
                              input logic [31:0] wdata, input logic cw,
                              input logic cpu, done, err, input logic [6:0] wc);
    vec_t t;
    t.rst = r; t.start = s; t.vld = v; t.d = d; t.pc = p;
    t.rdy = rdy; t.we = we; t.addr = addr; t.ca = ca; t.wdata = wdata; t.cw = cw;
    t.cpu = cpu; t.done = done; t.err = err; t.wc = wc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample 1 time unit later
  task automatic tick(input logic r, s, v, input logic [7:0] d, input logic [31:0] p);
    @(negedge clk);
    rst = r; start = s; rx_valid = v; rx_data = d; pc = p;
    #1;
    if (mem_we === 1'b1 && wr_n < 128) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n++;
    end
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Offer a byte until accepted; optional idle cycle first
  task automatic send_byte(input logic [7:0] d, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) tick(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int k = 0; k < 20 && !ok; k++) begin
      tick(1'b0, 1'b0, 1'b1, d, 32'h0);
      ok = (rx_ready === 1'b1);
    end
    if (!ok) chk("send_byte timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int b = 0; b < 4; b++) send_byte(8'(w >> (8 * b)), gap);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      seen = (load_done === 1'b1);
    end
    chk({name, " load_done"}, 32'(seen), 32'd1);
  endtask

  task automatic load_image(input int n, input bit gap, input string name);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    send_byte(8'(n), gap);
    send_byte(8'(n >> 8), gap);
    for (int w = 0; w < n; w++) send_word(img[w], gap);
    wait_done(name);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc = 32'h0;

    // basic load, start in DONE, N=0 and N=65 errors, start in ERROR, 1-word load
    vecs.push_back(mk(0,1,0,8'h00,32'h0,   0,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h02,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h13,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h20,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h08,32'h0,   0,1,32'h0,1,32'h20000013,1, 1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h08,32'h0,   1,0,32'h4,1,32'h0,0,        1,0,0,7'd1));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h4,1,32'h0,0,        1,0,0,7'd1));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h4,1,32'h0,0,        1,0,0,7'd1));
    vecs.push_back(mk(0,0,1,8'hAC,32'h0,   1,0,32'h4,1,32'h0,0,        1,0,0,7'd1));
    vecs.push_back(mk(0,0,0,8'h00,32'h0,   0,1,32'h4,1,32'hAC000008,1, 1,0,0,7'd1));
    vecs.push_back(mk(0,0,0,8'h00,32'h4,   0,0,32'h4,1,32'h0,0,        0,1,0,7'd2));
    vecs.push_back(mk(0,0,0,8'h00,32'h100, 0,0,32'h100,1,32'h0,0,      0,1,0,7'd2));
    vecs.push_back(mk(0,1,0,8'h00,32'h200, 0,0,32'h200,1,32'h0,0,      0,1,0,7'd2));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h0,0,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h0,0,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h41,32'h0,   0,0,32'h0,0,32'h0,0,        1,0,1,7'd0));
    vecs.push_back(mk(0,1,0,8'h00,32'h0,   0,0,32'h0,0,32'h0,0,        1,0,1,7'd0));
    vecs.push_back(mk(0,0,1,8'h41,32'h0,   1,0,32'h0,0,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h0,0,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,0,8'h00,32'h0,   0,0,32'h0,0,32'h0,0,        1,0,1,7'd0));
    vecs.push_back(mk(0,1,0,8'h00,32'h0,   0,0,32'h0,0,32'h0,0,        1,0,1,7'd0));
    vecs.push_back(mk(0,0,1,8'h01,32'h0,   1,0,32'h0,0,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h00,32'h0,   1,0,32'h0,0,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h78,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,0,8'h00,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h56,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h34,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,1,8'h12,32'h0,   1,0,32'h0,1,32'h0,0,        1,0,0,7'd0));
    vecs.push_back(mk(0,0,0,8'h00,32'h0,   0,1,32'h0,1,32'h12345678,1, 1,0,0,7'd0));
    vecs.push_back(mk(0,0,0,8'h00,32'h8,   0,0,32'h8,1,32'h0,0,        0,1,0,7'd1));

    // reset values
    do_reset();
    chk("reset rx_ready",   32'(rx_ready),   32'd0);
    chk("reset mem_we",     32'(mem_we),     32'd0);
    chk("reset mem_wdata",  mem_wdata,       32'd0);
    chk("reset mem_addr",   mem_addr,        32'd0);
    chk("reset cpu_rst",    32'(cpu_rst),    32'd1);
    chk("reset load_done",  32'(load_done),  32'd0);
    chk("reset load_error", 32'(load_error), 32'd0);
    chk("reset word_count", 32'(word_count), 32'd0);

    // cycle-by-cycle table
    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].start, vecs[i].vld, vecs[i].d, vecs[i].pc);
      chk($sformatf("v%0d rx_ready", i), 32'(rx_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      if (vecs[i].ca) chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      if (vecs[i].cw) chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
      chk($sformatf("v%0d cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].cpu));
      chk($sformatf("v%0d load_done", i), 32'(load_done), 32'(vecs[i].done));
      chk($sformatf("v%0d load_error", i), 32'(load_error), 32'(vecs[i].err));
      chk($sformatf("v%0d word_count", i), 32'(word_count), 32'(vecs[i].wc));
    end

    // alternate-cycle gaps, valid held high through WRITE
    do_reset();
    wr_n = 0;
    img[0] = 32'h20000013;
    img[1] = 32'hAC000008;
    load_image(2, 1'b1, "gap");
    chk("gap writes", 32'(wr_n), 32'd2);
    chk("gap addr0", wr_addr[0], 32'h0);
    chk("gap data0", wr_data[0], 32'h20000013);
    chk("gap addr1", wr_addr[1], 32'h4);
    chk("gap data1", wr_data[1], 32'hAC000008);
    chk("gap word_count", 32'(word_count), 32'd2);
    chk("gap cpu_rst", 32'(cpu_rst), 32'd0);

    // maximum image length
    do_reset();
    wr_n = 0;
    for (int i = 0; i < 64; i++) img[i] = (32'(i) * 32'h01030507) ^ 32'h5A5A0000;
    load_image(64, 1'b0, "full");
    chk("full writes", 32'(wr_n), 32'd64);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("full addr%0d", i), wr_addr[i], 32'(i) * 32'd4);
      chk($sformatf("full data%0d", i), wr_data[i], (32'(i) * 32'h01030507) ^ 32'h5A5A0000);
    end
    chk("full last addr", wr_addr[63], 32'hFC);
    chk("full word_count", 32'(word_count), 32'd64);

    // reset after the 2nd byte of word 1
    do_reset();
    wr_n = 0;
    tick(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hDD, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("rstmid rx_ready", 32'(rx_ready), 32'd0);
    chk("rstmid cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rstmid word_count", 32'(word_count), 32'd0);
    chk("rstmid mem_we", 32'(mem_we), 32'd0);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("rstmid writes", 32'(wr_n), 32'd1);
    wr_n = 0;
    img[0] = 32'hCAFEF00D;
    img[1] = 32'h0BADBEEF;
    load_image(2, 1'b0, "reload");
    chk("reload writes", 32'(wr_n), 32'd2);
    chk("reload addr0", wr_addr[0], 32'h0);
    chk("reload data0", wr_data[0], 32'hCAFEF00D);
    chk("reload addr1", wr_addr[1], 32'h4);
    chk("reload data1", wr_data[1], 32'h0BADBEEF);

    // start pulsed mid-word is ignored
    do_reset();
    wr_n = 0;
    tick(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b0);
    wait_done("startdata");
    chk("startdata writes", 32'(wr_n), 32'd1);
    chk("startdata data0", wr_data[0], 32'hD4C3B2A1);
    chk("startdata word_count", 32'(word_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
